// File: rtl/mipi_csi_packet_decoder_4lane.sv
// mipi_csi_packet_decoder_4lane: 4-lane CSI-2 sync/header parser forwarding RAW8/10/12/14 payload words.
// Optional header ECC check: define MIPI_CSI_DECODER_HEADER_ECC_EN.
module mipi_csi_packet_decoder_4lane #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        output_valid_o,
    output logic [31:0] data_o,
    output logic [15:0] packet_length_o,
    output logic [2:0]  packet_type_o
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t      state, state_n;
    logic [15:0] remaining, remaining_n, length_n;
    logic [2:0]  type_n;
    logic        valid_n, dt_ok, ecc_ok, last;
    logic [31:0] data_n;
    logic [15:0] wc;

    assign wc    = data_i[23:8];
    assign dt_ok = data_i[5:0] >= 6'h2A && data_i[5:0] <= 6'h2D;
    assign last  = remaining <= 16'd4;

`ifdef MIPI_CSI_DECODER_HEADER_ECC_EN
    // Each parity bit is the XOR of the header bits selected by its CSI-2 mask.
    logic [5:0] ecc;
    assign ecc = {^(data_i[23:0] & 24'hEFFC00), ^(data_i[23:0] & 24'hDF03F0),
                  ^(data_i[23:0] & 24'hB8E38E), ^(data_i[23:0] & 24'h749A6D),
                  ^(data_i[23:0] & 24'hF2555B), ^(data_i[23:0] & 24'hF12CB7)};
    assign ecc_ok = ecc == data_i[29:24];
`else
    assign ecc_ok = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= IDLE;
            remaining       <= '0;
            output_valid_o  <= 1'b0;
            data_o          <= '0;
            packet_length_o <= '0;
            packet_type_o   <= '0;
        end else begin
            state           <= state_n;
            remaining       <= remaining_n;
            output_valid_o  <= valid_n;
            data_o          <= data_n;
            packet_length_o <= length_n;
            packet_type_o   <= type_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        length_n    = packet_length_o;
        type_n      = packet_type_o;
        valid_n     = 1'b0;
        data_n      = data_o;
        case (state)
            IDLE: state_n = (data_valid_i && data_i == {4{SYNC_BYTE}}) ? HEADER : IDLE;
            HEADER: begin
                state_n = IDLE;
                if (data_valid_i && dt_ok && ecc_ok) begin
                    length_n    = wc;
                    type_n      = data_i[2:0];
                    remaining_n = wc;
                    state_n     = (wc != 16'd0) ? PAYLOAD : IDLE;
                end
            end
            PAYLOAD: begin
                state_n = IDLE;
                if (data_valid_i) begin
                    data_n      = data_i;
                    valid_n     = 1'b1;
                    remaining_n = last ? 16'd0 : remaining - 16'd4;
                    state_n     = last ? IDLE : PAYLOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mipi_csi_packet_decoder_4lane.sv
// tb_mipi_csi_packet_decoder_4lane: cycle-exact scoreboard bench for the CSI-2 packet decoder.
module tb_mipi_csi_packet_decoder_4lane;
    localparam logic [31:0] SYNC = 32'hB8B8B8B8;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        data_valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        output_valid_o;
    logic [31:0] data_o;
    logic [15:0] packet_length_o;
    logic [2:0]  packet_type_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   outs = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    mipi_csi_packet_decoder_4lane dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .data_valid_i(data_valid_i),
        .data_i(data_i),
        .output_valid_o(output_valid_o),
        .data_o(data_o),
        .packet_length_o(packet_length_o),
        .packet_type_o(packet_type_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle either a scheduled payload word appears or output_valid_o must be low.
    always @(negedge clk_i) begin
        exp_t e;
        if (mon_en) begin
            if (output_valid_o === 1'b1) outs++;
            if (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("out_valid", {31'd0, output_valid_o}, 32'd1);
                check("out_data", data_o, e.d);
            end else begin
                check("idle_valid", {31'd0, output_valid_o}, 32'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input bit expect_out);
        @(posedge clk_i);
        #1;
        data_valid_i = v;
        data_i = d;
        if (expect_out) q.push_back('{cyc + 1, d});
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 32'd0, 1'b0);
    endtask

    task automatic drain(input string tag);
        gap(3);
        check(tag, q.size(), 0);
    endtask

    task automatic burst(input logic [31:0] hdr, input logic [2:0] t);
        int start;
        start = outs;
        drive(1'b1, SYNC, 1'b0);
        drive(1'b1, hdr, 1'b0);
        drive(1'b1, 32'h11223344, 1'b1);
        drive(1'b1, 32'h55667788, 1'b1);
        drive(1'b1, 32'h99AABBCC, 1'b1);
        for (int i = 0; i <= 'h4BC; i += 4) drive(1'b1, i * 1000, 1'b1);
        drain("burst_drain");
        check("burst_count", outs - start, 307);
        check("burst_type", {29'd0, packet_type_o}, {29'd0, t});
        check("burst_len", {16'd0, packet_length_o}, 32'h0A06);
    endtask

    initial begin
        logic [31:0] w;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        check("rst_valid", {31'd0, output_valid_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        check("rst_len", {16'd0, packet_length_o}, 32'd0);
        check("rst_type", {29'd0, packet_type_o}, 32'd0);
        mon_en = 1'b1;

        gap(6);
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            if (w == SYNC) w = 32'h0;
            drive(1'b1, w, 1'b0);
        end
        drain("idle_drain");
        check("idle_data", data_o, 32'd0);
        check("idle_len", {16'd0, packet_length_o}, 32'd0);
        check("idle_type", {29'd0, packet_type_o}, 32'd0);

        burst(32'hDD0A062B, 3'd3);
        burst(32'hDD0A062C, 3'd4);
        burst(32'hDD0A062D, 3'd5);

        drive(1'b1, SYNC, 1'b0);
        drive(1'b1, 32'h00001200, 1'b0);
        drive(1'b1, 32'h11223344, 1'b0);
        drive(1'b1, 32'h55667788, 1'b0);
        drain("short_drain");
        check("short_len", {16'd0, packet_length_o}, 32'h0A06);
        check("short_type", {29'd0, packet_type_o}, 32'd5);

        drive(1'b1, SYNC, 1'b0);
        drive(1'b1, 32'hDD0A062B, 1'b0);
        drive(1'b1, 32'hCAFE0001, 1'b1);
        drive(1'b1, 32'hCAFE0002, 1'b1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        data_i = 32'hCAFE0003;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        check("mid_rst_valid", {31'd0, output_valid_o}, 32'd0);
        check("mid_rst_data", data_o, 32'd0);
        check("mid_rst_len", {16'd0, packet_length_o}, 32'd0);
        check("mid_rst_type", {29'd0, packet_type_o}, 32'd0);
        for (int i = 4; i < 10; i++) drive(1'b1, 32'hCAFE0000 + i, 1'b0);
        drain("post_rst_drain");

        drive(1'b1, SYNC, 1'b0);
        drive(1'b1, 32'h0000082B, 1'b0);
        drive(1'b1, 32'hA5A5A5A5, 1'b1);
        drive(1'b1, 32'h5A5A5A5A, 1'b1);
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        drive(1'b1, 32'h0000082B, 1'b0);
        drive(1'b1, 32'h01020304, 1'b0);
        drain("exact_drain");
        check("exact_len", {16'd0, packet_length_o}, 32'd8);
        check("exact_type", {29'd0, packet_type_o}, 32'd3);
        check("exact_hold", data_o, 32'h5A5A5A5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mipi_csi_packet_decoder_4lane.md
Name: mipi_csi_packet_decoder_4lane

Overview:
- Receives 32-bit words from a 4-lane MIPI CSI-2 D-PHY byte aligner: one byte per lane per clock, lane 0 in bits [7:0].
- Detects the sync word and parses the long-packet header (data ID, word count, ECC).
- Forwards the RAW pixel payload words downstream, with a valid strobe, the packet word count and a compact packet-type code.
- Sits between the lane aligner and the RAW10/12/14 pixel unpacker.

Parameters:
- SYNC_BYTE, 8'hB8, D-PHY sync byte expected on each lane.

Ports:
- clk_i  input  1  byte clock; all logic on rising edge.
- reset_i  input  1  synchronous reset, active-high.
- data_valid_i  input  1  data_i holds a valid aligned 4-lane word this cycle.
- data_i  input  32  lane bytes; [7:0] lane0, [15:8] lane1, [23:16] lane2, [31:24] lane3.
- output_valid_o  output  1  data_o holds a payload word.
- data_o  output  32  payload word, byte order unchanged from data_i.
- packet_length_o  output  16  word count (bytes) of the current or last long packet.
- packet_type_o  output  3  data-type code of the current or last packet (data ID bits [2:0]).

Behaviour:
- Reset, synchronous and active-high:
  - All outputs go to 0; state goes to IDLE.
  - Reset has priority over every other condition, including mid-payload: the next cycle has output_valid_o=0.
- All outputs are registered.
- A payload word sampled at edge N appears on data_o, with output_valid_o=1, after edge N (1-cycle latency).
- State machine, states IDLE, HEADER, PAYLOAD:
  - IDLE: when data_valid_i=1 and all four bytes equal SYNC_BYTE (32'hB8B8B8B8), go to HEADER. Otherwise stay.
  - HEADER, on a data_valid_i=1 cycle:
    - Data ID is data_i[7:0]; bits [7:6] are the virtual channel and are ignored.
    - Word count WC is data_i[23:8] (low byte in [15:8]); ECC is data_i[31:24].
    - If DT=data_i[5:0] is one of 0x2A RAW8, 0x2B RAW10, 0x2C RAW12, 0x2D RAW14: load packet_length_o<=WC, packet_type_o<=data_i[2:0], remaining<=WC, and go to PAYLOAD.
    - Any other DT (short packets, e.g. 0x00 frame start or 0x01 frame end, and unsupported long types) returns to IDLE with packet_length_o and packet_type_o unchanged.
    - If data_valid_i=0 in HEADER, return to IDLE.
  - PAYLOAD, each data_valid_i=1 cycle:
    - data_o<=data_i; output_valid_o<=1; remaining<=remaining-4.
    - If remaining<=4 this is the last word: go to IDLE after it.
    - A partial final word (WC not a multiple of 4) is output whole; the downstream block discards the excess bytes.
- In PAYLOAD, data_valid_i=0 terminates the packet (truncated burst): output_valid_o<=0 and state<=IDLE. No error flag.
- WC=0 in a valid header: go directly to IDLE; no payload words are output.
- output_valid_o is 0 in every cycle not covered by the PAYLOAD rule above.
- data_o holds its last value when output_valid_o=0.
- packet_length_o and packet_type_o hold until the next accepted header.
- remaining is a 16-bit register with no wrap: the "<=4" compare prevents underflow.

Optional Feature:
- Macro MIPI_CSI_DECODER_HEADER_ECC_EN.
- Defined:
  - The 6-bit CSI-2 header ECC is computed over data_i[23:0] and compared with data_i[29:24].
  - On mismatch, the header is rejected (return to IDLE, no output, length/type unchanged).
  - There is no single-bit correction.
- Undefined: the ECC byte is ignored and any supported DT is accepted. This is the default build.

Test Plan:
- Idle rejection: data_valid_i=0 with data_i=0 for 6 cycles, then data_valid_i=1 with random non-sync words -> output_valid_o stays 0 and all outputs stay 0.
- RAW10, truncated burst (macro undefined):
  - Sequence: B8B8B8B8, then DD0A062B, then 11223344, 55667788, 99AABBCC, then 304 words i*1000 (i=0,4,...,0x4BC), then data_valid_i=0.
  - Expect packet_type_o=3 and packet_length_o=0x0A06.
  - data_o=11223344 with output_valid_o=1 one cycle after it is input.
  - Exactly 307 valid outputs, in order; output_valid_o=0 the cycle after valid drops.
- RAW12 and RAW14: same sequence with headers DD0A062C and DD0A062D -> packet_type_o=4 and 5 respectively, same 307-word payload behaviour.
- Exact-length termination: header 000008 2B (WC=8) followed by 3 valid words -> exactly 2 outputs; the third word is ignored; state returns to IDLE.
- Short/unsupported packet: B8B8B8B8 then 00001200 (frame start), then data words -> no output_valid_o; packet_length_o and packet_type_o unchanged.
- Reset mid-payload: assert reset_i during the RAW10 payload -> the next cycle has all outputs 0, and subsequent words are ignored until a new sync word arrives.
